// File: rtl/fifo_param_if.sv
// fifo_param_if: handshake/status bundle for fifo_param.
//   master modport : producer/consumer side; drives clr, wr_en, wr_data, rd_en
//                    and observes read data, rd_valid, flags, count and errors.
//   slave modport  : the FIFO itself; the mirror image of master.
// WIDTH and DEPTH must match the parameters of the attached fifo_param.
interface fifo_param_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic              clr;
   logic              wr_en;
   logic [WIDTH-1:0]  wr_data;
   logic              rd_en;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output clr, wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  clr, wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with independent push and pop.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : fifo_param_if.slave
//          clr          synchronous flush (also clears error flags)
//          wr_en/wr_data push request and data
//          rd_en        pop request
//          rd_data      registered pop data, held when no pop
//          rd_valid     one-cycle strobe, rd_data carries a new word
//          full/empty/almost_full/almost_empty/count  occupancy status
//          overflow/underflow  sticky rejected-push / rejected-pop flags
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
module fifo_param #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2
) (
   input logic          clk,
   input logic          rst,
   fifo_param_if.slave  bus
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_THR = (ADDR_W+1)'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W:0]  wr_ptr;
   logic [ADDR_W:0]  rd_ptr;
   logic [ADDR_W:0]  count;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             overflow;
   logic             underflow;
   logic             full;
   logic             empty;
   logic             rd_acc;
   logic             wr_acc;

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

   // clr drops both requests; a push into a full FIFO is still accepted
   // when a pop frees a slot in the same cycle.
   assign rd_acc = bus.rd_en && !empty && !bus.clr;
   assign wr_acc = bus.wr_en && !bus.clr && (!full || rd_acc);

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (bus.clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) begin
            rd_data <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr  <= rd_ptr + 1'b1;
         end
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (bus.wr_en && !wr_acc) begin
            overflow <= 1'b1;
         end
         if (bus.rd_en && !rd_acc) begin
            underflow <= 1'b1;
         end
      end
   end

   assign bus.rd_data      = rd_data;
   assign bus.rd_valid     = rd_valid;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.count        = count;
   assign bus.almost_full  = (count >= AF_THR);
   assign bus.almost_empty = (count <= AE_THR);
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: scoreboard bench for fifo_param (WIDTH=8, DEPTH=8,
// default thresholds AF=6, AE=2).
module tb_fifo_param;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int               checks   = 0;
   int               failures = 0;
   logic [WIDTH-1:0] sb[$];
   int               mcount   = 0;
   bit               movf     = 1'b0;
   bit               munf     = 1'b0;
   logic [WIDTH-1:0] last_rd  = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input bit exp_valid);
      check("count",        32'(bus.count),        32'(mcount));
      check("full",         32'(bus.full),         32'(mcount == DEPTH));
      check("empty",        32'(bus.empty),        32'(mcount == 0));
      check("almost_full",  32'(bus.almost_full),  32'(mcount >= 6));
      check("almost_empty", 32'(bus.almost_empty), 32'(mcount <= 2));
      check("overflow",     32'(bus.overflow),     32'(movf));
      check("underflow",    32'(bus.underflow),    32'(munf));
      check("rd_valid",     32'(bus.rd_valid),     32'(exp_valid));
      if (bus.rd_valid === 1'b1) begin
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) last_rd = sb.pop_front();
      end
      check("rd_data", 32'(bus.rd_data), 32'(last_rd));
   endtask

   task automatic cycle(input bit c, input bit w, input logic [WIDTH-1:0] d, input bit r);
      bit racc;
      bit wacc;
      racc = r && (mcount != 0) && !c;
      wacc = w && !c && ((mcount != DEPTH) || racc);
      bus.clr     = c;
      bus.wr_en   = w;
      bus.wr_data = d;
      bus.rd_en   = r;
      @(posedge clk);
      #1;
      bus.clr   = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      if (c) begin
         mcount = 0;
         movf   = 1'b0;
         munf   = 1'b0;
         sb.delete();
      end else begin
         if (wacc) begin
            sb.push_back(d);
            mcount++;
         end
         if (racc) mcount--;
         if (w && !wacc) movf = 1'b1;
         if (r && !racc) munf = 1'b1;
      end
      check_state(racc);
   endtask

   initial begin
      bus.clr     = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.rd_en   = 1'b0;

      // reset then idle
      repeat (3) @(posedge clk);
      #1;
      check_state(1'b0);
      @(negedge clk);
      rst = 1'b1;
      cycle(0, 0, 8'h00, 0);

      // fill, overflow, drain
      for (int i = 1; i <= 8; i++) cycle(0, 1, 8'(i), 0);
      cycle(0, 1, 8'h09, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);
      cycle(1, 0, 8'h00, 0);

      // wrap-around
      for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h30 + i), 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1);
      for (int i = 0; i < 8; i++) cycle(0, 1, 8'(8'hA0 + i), 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);

      // simultaneous push/pop while full
      for (int i = 0; i < 8; i++) cycle(0, 1, 8'(8'h10 + i), 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'h09 + i), 1);
      for (int i = 0; i < 8; i++) cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);

      // simultaneous push/pop while empty
      cycle(0, 1, 8'h05, 1);
      cycle(0, 0, 8'h00, 1);
      cycle(1, 0, 8'h00, 0);

      // flush with overflow set, write in the same cycle is dropped
      for (int i = 0; i < 8; i++) cycle(0, 1, 8'(8'h40 + i), 0);
      cycle(0, 1, 8'h4F, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1);
      cycle(1, 1, 8'h55, 0);
      cycle(0, 0, 8'h00, 0);

      // asynchronous reset between clock edges
      cycle(0, 1, 8'h61, 0);
      cycle(0, 1, 8'h62, 0);
      #2;
      rst = 1'b0;
      #1;
      mcount  = 0;
      movf    = 1'b0;
      munf    = 1'b0;
      last_rd = '0;
      sb.delete();
      check_state(1'b0);
      @(negedge clk);
      rst = 1'b1;
      cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO that succeeds the single-port 4x8 read-or-write FIFO. It has independent write and read enables, so a push and a pop can happen in the same cycle, and width and depth are configurable. It also provides an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a synchronous flush. It sits between producer and consumer logic within one clock domain.

Parameters:
WIDTH, 4, data word width in bits (>=1)
DEPTH, 8, number of entries; must be a power of two, >=2
ADDR_W, log2(DEPTH), pointer index width (derived, not overridden)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
clr  input  1  synchronous flush; empties FIFO and clears error flags
wr_en  input  1  push request
wr_data  input  WIDTH  push data
rd_en  input  1  pop request
rd_data  output  WIDTH  registered pop data
rd_valid  output  1  high for one cycle when rd_data carries a newly popped word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: push rejected
underflow  output  1  sticky: pop rejected

Behaviour:
- Reset (rst low, asynchronous): pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0). Memory contents are not reset.
- Pointers: write and read pointers are ADDR_W+1 bits and wrap naturally modulo 2*DEPTH. Memory is indexed by the low ADDR_W bits.
- full: pointers equal in the low bits and differ in the MSB. empty: pointers fully equal. count = wr_ptr - rd_ptr, mod 2^(ADDR_W+1).
- All flags and count are combinational from registered pointers and reflect state after the last clock edge.
- Pop accepted (rd_acc) = rd_en && !empty. On rd_acc: rd_data <= mem[rd_ptr], rd_ptr++, rd_valid=1 in the next cycle. Read latency is 1 clock.
- Without rd_acc: rd_valid=0 and rd_data holds its last value. rd_data is never driven high-Z.
- Push accepted (wr_acc) = wr_en && (!full || rd_acc). On wr_acc: mem[wr_ptr] <= wr_data, wr_ptr++.
- Simultaneous push and pop when full: both are accepted; count stays DEPTH and the popped word is the oldest entry.
- Simultaneous push and pop when empty: only the push is accepted, with no bypass. Count becomes 1, rd_valid=0, and underflow is set.
- Simultaneous accepted push and pop otherwise: count is unchanged.
- overflow is set on any cycle with wr_en && !wr_acc. underflow is set on any cycle with rd_en && !rd_acc. Both hold until clr or reset.
- clr=1 at a clock edge takes priority over wr_en and rd_en in the same cycle. Pointers=0, count=0, rd_valid=0, overflow=0, underflow=0; rd_data holds. Requests in that cycle are dropped and do not set error flags.
- Reset asserted mid-operation: immediate return to reset state, independent of clk. Release is synchronised externally.
- Pointers hold when there is no accepted operation. Data order is strict FIFO across wrap-around.

Test Plan:
- Reset then idle: rst low for 3 cycles -> empty=1, full=0, count=0, almost_empty=1, rd_data=0, overflow=0, underflow=0.
- Fill and drain (defaults): push 1..8 -> full=1, count=8, almost_full from count 6. A 9th push -> overflow=1, count stays 8. Pop 8 -> rd_data 1..8 each with rd_valid one cycle after rd_en; empty=1 after the last pop.
- Wrap-around: push 5, pop 5, then push 8 values A0..A7 and pop all -> order A0..A7 preserved, count peaks at 8, no errors.
- Simultaneous when full: full FIFO, wr_en=rd_en=1 for 4 cycles with data 9..C -> count stays 8, oldest 4 words emerge, overflow stays 0. Then drain -> remaining 4 originals, then 9..C.
- Empty edge: empty FIFO, rd_en=wr_en=1 with data 5 -> count=1, rd_valid=0, underflow=1. The next pop returns 5.
- Flush and async reset: 3 entries with overflow set, clr=1 with wr_en=1 -> count=0, empty=1, overflow=0, the write is dropped. Then push 2 and drop rst low between edges -> count=0 immediately.
